// File: rtl/adc_trigger.sv
// Shot-arrival trigger for one microphone channel: learns a quiet baseline, then
// raises start on a sustained excursion. Optional timestamp: ADC_TRIGGER_TIMESTAMP_EN.
module adc_trigger #(
  parameter int WIDTH      = 8,
  parameter int BASE_SHIFT = 4,
  parameter int CONFIRM    = 2,
  parameter int HOLDOFF    = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_wr,
  input  logic [WIDTH-1:0] threshold,
  input  logic             arm,
  input  logic             clear,
  output logic             start,
  output logic [2:0]       state_o,
  output logic [WIDTH-1:0] baseline,
  output logic [WIDTH-1:0] peak,
  output logic [15:0]      trig_time
);
  localparam int AW = WIDTH + BASE_SHIFT;
  localparam int HW = $clog2(HOLDOFF + 1);
  localparam logic [BASE_SHIFT:0] LAST_SMP = {(BASE_SHIFT+1){1'b1}} >> 1;
  localparam logic [3:0]          CONF_M1  = 4'(CONFIRM - 1);
  localparam logic [HW-1:0]       HOLD_M1  = HW'(HOLDOFF - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BASE  = 3'd1,
    S_ARMED = 3'd2,
    S_TRIG  = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t                  state;
  logic [AW-1:0]           acc, sum;
  logic [BASE_SHIFT:0]     scnt;
  logic [3:0]              qcnt;
  logic [HW-1:0]           hcnt;
  logic signed [WIDTH:0]   diff;
  logic [WIDTH-1:0]        mag;
  logic                    over, base_done, fire;

  // One extra bit keeps the difference exact; |diff| never exceeds 2^WIDTH-1.
  assign diff = $signed({1'b0, sample_in}) - $signed({1'b0, baseline});
  assign mag  = diff[WIDTH] ? WIDTH'(-diff) : WIDTH'(diff);
  assign sum  = acc + AW'(sample_in);
  assign over = mag > threshold;

  assign base_done = (state == S_BASE) && sample_wr && (scnt == LAST_SMP) && !clear;
  assign fire      = (state == S_ARMED) && sample_wr && over && (qcnt == CONF_M1) && !clear;

  assign state_o = state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      start    <= 1'b0;
      baseline <= '0;
      peak     <= '0;
      acc      <= '0;
      scnt     <= '0;
      qcnt     <= '0;
      hcnt     <= '0;
    end else begin
      case (state)
        S_IDLE: if (arm && !clear) begin
          state <= S_BASE;
          acc   <= '0;
          scnt  <= '0;
        end
        S_BASE: begin
          if (clear) begin
            state <= S_IDLE;
          end else if (base_done) begin
            baseline <= sum[AW-1:BASE_SHIFT];
            peak     <= '0;
            qcnt     <= '0;
            state    <= S_ARMED;
          end else if (sample_wr) begin
            acc  <= sum;
            scnt <= scnt + 1'b1;
          end
        end
        S_ARMED: begin
          if (clear) begin
            state <= S_IDLE;
          end else if (sample_wr) begin
            if (mag > peak) peak <= mag;
            if (fire) begin
              state <= S_TRIG;
              start <= 1'b1;
            end else if (over) begin
              qcnt <= qcnt + 1'b1;
            end else begin
              qcnt <= '0;
            end
          end
        end
        S_TRIG: begin
          if (clear) begin
            state <= S_HOLD;
            start <= 1'b0;
            hcnt  <= '0;
          end else if (sample_wr && mag > peak) begin
            peak <= mag;
          end
        end
        S_HOLD: begin
          // Counts clock cycles, not samples, so the dead time is rate independent.
          if (hcnt == HOLD_M1) state <= S_IDLE;
          else                 hcnt  <= hcnt + 1'b1;
        end
        default: begin
          state <= S_IDLE;
          start <= 1'b0;
        end
      endcase
    end
  end

`ifdef ADC_TRIGGER_TIMESTAMP_EN
  logic [15:0] ts, ts_next;
  assign ts_next = (ts == 16'hFFFF) ? ts : ts + 16'd1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ts        <= '0;
      trig_time <= '0;
    end else if (base_done) begin
      ts        <= '0;
      trig_time <= '0;
    end else if (state == S_ARMED && sample_wr) begin
      ts <= ts_next;
      if (fire) trig_time <= ts_next;
    end
  end
`else
  assign trig_time = 16'h0000;
`endif

endmodule

// File: tb/tb_adc_trigger.sv
// Directed bench for adc_trigger: baseline learning, trigger, holdoff and reset paths.
module tb_adc_trigger;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] sample_in;
  logic       sample_wr;
  logic [7:0] threshold;
  logic       arm;
  logic       clear;
  logic       start;
  logic [2:0] state_o;
  logic [7:0] baseline;
  logic [7:0] peak;
  logic [15:0] trig_time;

  int tests = 0;
  int fails = 0;

`ifdef ADC_TRIGGER_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  adc_trigger #(.WIDTH(8), .BASE_SHIFT(4), .CONFIRM(2), .HOLDOFF(16)) dut (
    .clk(clk), .reset_n(reset_n), .sample_in(sample_in), .sample_wr(sample_wr),
    .threshold(threshold), .arm(arm), .clear(clear), .start(start),
    .state_o(state_o), .baseline(baseline), .peak(peak), .trig_time(trig_time)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] s);
    sample_in = s;
    sample_wr = 1'b1;
    tick();
    sample_wr = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; sample_in = 8'h80; sample_wr = 1'b0;
    threshold = 8'h10; arm = 1'b1; clear = 1'b0;

    // Reset with arm held and strobes toggling
    sample_wr = 1'b1; tick();
    sample_wr = 1'b0; tick();
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_base", 32'(baseline), 32'd0);
    chk("rst_peak", 32'(peak), 32'd0);
    chk("rst_ttime", 32'(trig_time), 32'd0);
    reset_n = 1'b1; arm = 1'b0;
    tick();

    // Baseline learning and positive trigger
    pulse_arm();
    chk("arm_state", 32'(state_o), 32'd1);
    for (int i = 0; i < 15; i++) send(8'h80);
    chk("base15_state", 32'(state_o), 32'd1);
    send(8'h80);
    chk("base_val", 32'(baseline), 32'h80);
    chk("armed_state", 32'(state_o), 32'd2);
    send(8'h95);
    chk("pos1_start", 32'(start), 32'd0);
    chk("pos1_state", 32'(state_o), 32'd2);
    send(8'h96);
    chk("pos_start", 32'(start), 32'd1);
    chk("pos_state", 32'(state_o), 32'd3);
    chk("pos_peak", 32'(peak), 32'h16);
    chk("pos_ttime", 32'(trig_time), TS_EN ? 32'd2 : 32'd0);

    // Clear and holdoff: clear sampled at edge E0
    pulse_clear();
    chk("clr_start", 32'(start), 32'd0);
    chk("clr_state", 32'(state_o), 32'd4);
    for (int i = 0; i < 4; i++) tick();
    pulse_arm();                         // sampled at E5, ignored
    chk("hold_arm_ign", 32'(state_o), 32'd4);
    send(8'hFF);                         // E6, sample ignored in HOLDOFF
    for (int i = 0; i < 9; i++) tick();  // E15
    chk("hold_e15", 32'(state_o), 32'd4);
    tick();                              // E16
    chk("hold_e16", 32'(state_o), 32'd0);
    chk("hold_peak", 32'(peak), 32'h16);
    for (int i = 0; i < 3; i++) tick();  // E19
    pulse_arm();                         // E20
    chk("rearm_state", 32'(state_o), 32'd1);

    // Negative swing with qualify reset
    for (int i = 0; i < 16; i++) send(8'h80);
    chk("neg_armed", 32'(state_o), 32'd2);
    chk("neg_ttime_clr", 32'(trig_time), 32'd0);
    send(8'h60);
    chk("neg1_start", 32'(start), 32'd0);
    send(8'h85);
    chk("neg2_start", 32'(start), 32'd0);
    send(8'h60);
    chk("neg3_start", 32'(start), 32'd0);
    send(8'h60);
    chk("neg_start", 32'(start), 32'd1);
    chk("neg_peak", 32'(peak), 32'h20);
    chk("neg_ttime", 32'(trig_time), TS_EN ? 32'd4 : 32'd0);

    // Threshold boundary: mag equal to threshold never qualifies
    pulse_clear();
    for (int i = 0; i < 16; i++) tick();
    chk("bnd_idle", 32'(state_o), 32'd0);
    pulse_arm();
    for (int i = 0; i < 16; i++) send(8'h80);
    for (int i = 0; i < 40; i++) send((i % 2 == 0) ? 8'h90 : 8'h70);
    chk("bnd_start", 32'(start), 32'd0);
    chk("bnd_state", 32'(state_o), 32'd2);
    chk("bnd_peak", 32'(peak), 32'h10);
    chk("bnd_ttime", 32'(trig_time), 32'd0);

    // Simultaneous arm and clear in ARMED: clear wins
    arm = 1'b1; clear = 1'b1;
    tick();
    arm = 1'b0; clear = 1'b0;
    chk("ac_state", 32'(state_o), 32'd0);
    chk("ac_start", 32'(start), 32'd0);
    chk("ac_base", 32'(baseline), 32'h80);
    chk("ac_peak", 32'(peak), 32'h10);

    // Truncating average and threshold zero
    pulse_arm();
    for (int i = 0; i < 15; i++) send(8'h40);
    send(8'h4F);
    chk("trunc_base", 32'(baseline), 32'h40);
    threshold = 8'h00;
    send(8'h40);
    send(8'h41);
    chk("thz1_start", 32'(start), 32'd0);
    send(8'h3F);
    chk("thz_start", 32'(start), 32'd1);
    chk("thz_peak", 32'(peak), 32'h01);
    chk("thz_ttime", 32'(trig_time), TS_EN ? 32'd3 : 32'd0);

    // Reset while triggered
    reset_n = 1'b0;
    tick();
    chk("mrst_start", 32'(start), 32'd0);
    chk("mrst_state", 32'(state_o), 32'd0);
    chk("mrst_base", 32'(baseline), 32'd0);
    chk("mrst_ttime", 32'(trig_time), 32'd0);
    reset_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
